// File: rtl/fir_pkg.sv
// Shared constants, state encoding and output conversion for the TDM FIR engine.
package fir_pkg;

  localparam int unsigned NTAPS = 16;
  localparam int unsigned DW    = 8;
  localparam int unsigned ACC_W = 20;
  localparam int unsigned OW    = 16;
  localparam int unsigned AW    = $clog2(NTAPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // h[0] weights the newest sample.
  localparam logic signed [DW-1:0] COEF_RST [NTAPS] = '{
    -8'sd2, -8'sd1,  8'sd3,  8'sd4,
     8'sd1,  8'sd1,  8'sd1,  8'sd1,
     8'sd1,  8'sd1,  8'sd1,  8'sd1,
     8'sd1,  8'sd1,  8'sd1,  8'sd1
  };

  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((2 ** (OW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-(2 ** (OW - 1)));

  function automatic logic signed [OW-1:0] sat_to_ow(input logic signed [ACC_W-1:0] v);
    logic signed [OW-1:0] r;
    if (v > OUT_MAX)      r = {1'b0, {(OW-1){1'b1}}};
    else if (v < OUT_MIN) r = {1'b1, {(OW-1){1'b0}}};
    else                  r = v[OW-1:0];
    return r;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Registered signed multiply-accumulate; acc_nxt exposes the sum the next enabled edge will store.
module fir_mac_unit
  import fir_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [DW-1:0]    a,
  input  logic signed [DW-1:0]    b,
  output logic signed [ACC_W-1:0] acc_nxt
);

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  always_comb begin
    prod    = a * b;
    acc_nxt = acc_q + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
    acc_d   = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = acc_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

endmodule

// File: rtl/fir_tdm_sequencer.sv
// Time-multiplexed 16-tap FIR: delay line, coefficient bank and MAC sequencer.
// Optional FIR_SAT_EN: saturate the accumulator to OW bits instead of wrapping.
module fir_tdm_sequencer
  import fir_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] Xin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] Yout,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [DW-1:0] coef_data,
  output logic                 coef_ready,
  input  logic                 flush
);

  localparam logic [AW-1:0] K_LAST = AW'(NTAPS - 1);

  state_t               state_q, state_d;
  logic [AW-1:0]        k_q, k_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr;
  logic signed [DW-1:0] dl_q   [NTAPS];
  logic signed [DW-1:0] dl_d   [NTAPS];
  logic signed [DW-1:0] coef_q [NTAPS];
  logic signed [DW-1:0] coef_d [NTAPS];
  logic                 out_valid_q, out_valid_d;
  logic signed [OW-1:0] yout_q, yout_d;
  logic                 mac_clr, mac_en;
  logic signed [ACC_W-1:0] acc_nxt;

  assign rd_ptr     = wr_ptr_q - k_q;
  assign in_ready   = (state_q == IDLE);
  assign coef_ready = (state_q == IDLE);
  assign out_valid  = out_valid_q;
  assign Yout       = yout_q;

  fir_mac_unit u_mac (
    .clk     (Clk),
    .rst     (Rst),
    .clr     (mac_clr),
    .en      (mac_en),
    .a       (coef_q[k_q]),
    .b       (dl_q[rd_ptr]),
    .acc_nxt (acc_nxt)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    wr_ptr_d    = wr_ptr_q;
    dl_d        = dl_q;
    coef_d      = coef_q;
    out_valid_d = out_valid_q;
    yout_d      = yout_q;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;

    // Coefficient writes land at the accept edge, so a same-cycle sample uses them.
    if (coef_we && (state_q == IDLE)) coef_d[coef_addr] = coef_data;

    if (flush) begin
      state_d     = IDLE;
      k_d         = '0;
      wr_ptr_d    = '0;
      dl_d        = '{default: '0};
      out_valid_d = 1'b0;
      mac_clr     = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            dl_d[wr_ptr_q] = Xin;
            mac_clr        = 1'b1;
            k_d            = '0;
            state_d        = MAC;
          end
        end
        MAC: begin
          mac_en = 1'b1;
          k_d    = k_q + 1'b1;
          // The last product is folded in here so Yout loads on the same edge as acc.
          if (k_q == K_LAST) begin
            state_d     = OUT;
            out_valid_d = 1'b1;
`ifdef FIR_SAT_EN
            yout_d      = sat_to_ow(acc_nxt);
`else
            yout_d      = acc_nxt[OW-1:0];
`endif
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            wr_ptr_d    = wr_ptr_q + 1'b1;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      wr_ptr_q    <= '0;
      dl_q        <= '{default: '0};
      coef_q      <= COEF_RST;
      out_valid_q <= 1'b0;
      yout_q      <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      wr_ptr_q    <= wr_ptr_d;
      dl_q        <= dl_d;
      coef_q      <= coef_d;
      out_valid_q <= out_valid_d;
      yout_q      <= yout_d;
    end
  end

endmodule

// File: tb/tb_fir_tdm_sequencer.sv
// Self-checking bench for fir_tdm_sequencer against a sum-of-products reference model.
module tb_fir_tdm_sequencer;

  localparam int NT = 16;

  logic              Clk = 1'b0;
  logic              Rst;
  logic              in_valid, in_ready, out_valid, out_ready;
  logic signed [7:0] Xin;
  logic signed [15:0] Yout;
  logic              coef_we, coef_ready, flush;
  logic [3:0]        coef_addr;
  logic signed [7:0] coef_data;

  int total = 0;
  int bad   = 0;

  int coef_m [NT];
  int hist   [NT];   // hist[0] is the newest sample

  fir_tdm_sequencer dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Xin        (Xin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Yout       (Yout),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .coef_ready (coef_ready),
    .flush      (flush)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void model_default_coefs();
    int d [NT] = '{-2, -1, 3, 4, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    for (int i = 0; i < NT; i++) coef_m[i] = d[i];
  endfunction

  function automatic void model_clear_hist();
    for (int i = 0; i < NT; i++) hist[i] = 0;
  endfunction

  function automatic void model_push(input int x);
    for (int i = NT - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
  endfunction

  function automatic logic signed [15:0] model_y();
    int s = 0;
    for (int k = 0; k < NT; k++) s += coef_m[k] * hist[k];
`ifdef FIR_SAT_EN
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`endif
    return 16'(s);
  endfunction

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_coef(input int addr, input int val);
    check("coef_ready_idle", coef_ready, 1);
    coef_we = 1'b1; coef_addr = 4'(addr); coef_data = 8'(val);
    next_cycle();
    coef_we = 1'b0;
    coef_m[addr] = val;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    model_clear_hist();
  endtask

  // One sample through the engine; optional stall, latency check, MAC-time coef poke,
  // and a coefficient write issued in the same cycle as the accept.
  task automatic do_sample(input int x, input int stall, input bit chk_lat,
                           input bit poke, input bit wr_same, input int wa, input int wv);
    int cyc;
    logic signed [15:0] exp_y;
    check("in_ready_idle", in_ready, 1);
    Xin = 8'(x); in_valid = 1'b1;
    if (wr_same) begin
      coef_we = 1'b1; coef_addr = 4'(wa); coef_data = 8'(wv);
      coef_m[wa] = wv;
    end
    next_cycle();
    in_valid = 1'b0; coef_we = 1'b0;
    model_push(x);
    exp_y = model_y();
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      if (poke && cyc == 3) begin
        check("coef_ready_busy", coef_ready, 0);
        coef_we = 1'b1; coef_addr = 4'($urandom_range(0, 15)); coef_data = 8'($urandom);
      end
      next_cycle();
      coef_we = 1'b0;
      cyc++;
    end
    if (!out_valid) check("out_valid_timeout", out_valid, 1);
    // Accept edge plus 16 MAC edges: out_valid is seen 16 edges after the accept edge.
    if (chk_lat) check("latency", cyc, NT);
    check("yout", Yout, exp_y);
    for (int i = 0; i < stall; i++) begin
      next_cycle();
      check("hold_yout", Yout, exp_y);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    next_cycle();
    out_ready = 1'b0;
    check("valid_drop", out_valid, 0);
  endtask

  initial begin
    int lat;
    logic signed [15:0] exp_y;
    Rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; Xin = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; flush = 1'b0;
    model_default_coefs();
    model_clear_hist();
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b0;
    next_cycle();

    check("rst_in_ready", in_ready, 1);
    check("rst_coef_ready", coef_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_yout", Yout, 0);

    // Impulse through default coefficients, with latency check and a 5-cycle stall.
    do_sample(1, 5, 1'b1, 1'b0, 1'b0, 0, 0);
    for (int i = 1; i < NT; i++) do_sample(0, 0, 1'b0, 1'b0, 1'b0, 0, 0);

    // Step of 10s: first output -20, settling at 160.
    for (int i = 0; i < NT + 1; i++) do_sample(10, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    check("step_settled", Yout, 160);

    // Random samples with random backpressure.
    for (int i = 0; i < 20; i++)
      do_sample(int'($signed(8'($urandom))), int'($urandom_range(0, 3)), 1'b1, 1'b0, 1'b0, 0, 0);

    // Throughput with out_ready held high: accept-to-accept is 18 cycles.
    out_ready = 1'b1;
    Xin = 8'sd5; in_valid = 1'b1;
    next_cycle();
    model_push(5);
    lat = 0;
    while (!in_ready && lat < 40) begin
      next_cycle();
      lat++;
    end
    in_valid = 1'b0;
    check("throughput", lat + 1, NT + 2);
    exp_y = model_y();
    check("throughput_yout", Yout, exp_y);
    out_ready = 1'b0;

    // Flush mid-MAC: no output, clean delay line afterwards.
    Xin = 8'sd7; in_valid = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    repeat (5) next_cycle();
    do_flush();
    lat = 0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid) lat++;
      next_cycle();
    end
    check("flush_no_output", lat, 0);
    check("flush_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) do_sample(i == 0 ? 1 : 0, 0, 1'b0, 1'b0, 1'b0, 0, 0);

    // Coefficient load h[k]=k, impulse, with ignored writes during MAC.
    for (int k = 0; k < NT; k++) write_coef(k, k);
    do_flush();
    for (int i = 0; i < NT; i++) do_sample(i == 0 ? 1 : 0, 0, 1'b0, 1'b1, 1'b0, 0, 0);

    // Coefficient write in the same cycle as accept: the new h[0] is used.
    do_flush();
    do_sample(1, 0, 1'b0, 1'b0, 1'b1, 0, -9);
    do_sample(0, 0, 1'b0, 1'b0, 1'b1, 1, 50);

    // Overflow: all taps 127, samples 127.
    for (int k = 0; k < NT; k++) write_coef(k, 127);
    do_flush();
    for (int i = 0; i < NT; i++) do_sample(127, 0, 1'b0, 1'b0, 1'b0, 0, 0);
`ifdef FIR_SAT_EN
    check("overflow_sat", Yout, 32767);
`else
    check("overflow_wrap", Yout, -4080);
`endif

    // Reset mid-MAC restores default coefficients.
    Xin = 8'sd3; in_valid = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    repeat (4) next_cycle();
    Rst = 1'b1;
    #2;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_yout", Yout, 0);
    next_cycle();
    Rst = 1'b0;
    model_default_coefs();
    model_clear_hist();
    next_cycle();
    check("midrst_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) do_sample(i == 0 ? 1 : 0, 0, 1'b0, 1'b0, 1'b0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
